// File: rtl/test_out_uart.sv
// ---------------------------------------------------------------------------
// test_out_uart
//   Watches the cpu's 32-bit test_out debug bus. Every new value goes into a
//   small capture FIFO. Each queued value is sent on a UART TX line as
//   8 uppercase ASCII hex characters, most significant nibble first,
//   followed by CR LF.
//
//   Frame format: 8N1 by default.
//   Define TEST_OUT_UART_PARITY_EN to add an even-parity bit after the data
//   bits, giving 8E1.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (>= 2)
//   FIFO_DEPTH   : capture FIFO entries (power of 2, >= 2)
//   FIFO_AW      : log2(FIFO_DEPTH)
//
// Ports
//   clk      in   system clock, rising edge
//   rest     in   asynchronous active-high reset
//   test_out in   cpu debug value, sampled every rising edge
//   tx       out  UART serial output, idle high (registered)
//   busy     out  FIFO non-empty or frame in progress (registered)
//   overflow out  sticky: a changed value was dropped on a full FIFO
// ---------------------------------------------------------------------------
module test_out_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] test_out,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // ASCII code of one hex digit, in uppercase.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    // Character number idx of the line printed for word.
    function automatic logic [7:0] char_sel(input logic [31:0] word, input logic [3:0] idx);
        case (idx)
            4'd0:    return hex_ascii(word[31:28]);
            4'd1:    return hex_ascii(word[27:24]);
            4'd2:    return hex_ascii(word[23:20]);
            4'd3:    return hex_ascii(word[19:16]);
            4'd4:    return hex_ascii(word[15:12]);
            4'd5:    return hex_ascii(word[11:8]);
            4'd6:    return hex_ascii(word[7:4]);
            4'd7:    return hex_ascii(word[3:0]);
            4'd8:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    logic [31:0]        prev_q, prev_d;
    logic               prev_valid_q, prev_valid_d;
    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [31:0]        mem_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    state_e             state_q, state_d;
    logic [31:0]        word_q, word_d;
    logic [3:0]         char_idx_q, char_idx_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;

    logic       change_s, pop_s, push_ok_s, baud_last_s;
    logic [7:0] next_char_s;

    // Change detection and the FIFO push/pop bookkeeping.
    always_comb begin
        change_s  = !prev_valid_q || (test_out != prev_q);
        pop_s     = (state_q == ST_IDLE) && (count_q != '0);
        // A pop on the same edge frees a slot, so a full FIFO can still accept a push.
        push_ok_s = change_s && ((count_q < DEPTH_C) || pop_s);

        prev_d       = test_out;
        prev_valid_d = 1'b1;
        overflow_d   = overflow_q | (change_s & ~push_ok_s);

        mem_d = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = test_out;
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // TX FSM next-state logic.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        char_idx_d  = char_idx_q;
        bit_idx_d   = bit_idx_q;
        baud_d      = baud_q + BW'(1);
        baud_last_s = (baud_q == BAUD_LAST);
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (pop_s) begin
                    word_d     = mem_q[rd_ptr_q];
                    char_idx_d = 4'd0;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef TEST_OUT_UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef TEST_OUT_UART_PARITY_EN
            ST_PARITY: begin
                if (baud_last_s) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d = '0;
                    if (char_idx_q < 4'd9) begin
                        char_idx_d = char_idx_q + 4'd1;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic. It decodes the state being entered, so the registered
    // tx changes on the same edge as the state does.
    always_comb begin
        next_char_s = char_sel(word_d, char_idx_d);
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = next_char_s[bit_idx_d];
`ifdef TEST_OUT_UART_PARITY_EN
            ST_PARITY: tx_d = even_parity(next_char_s);
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE) || (count_d != '0);
    end

    // State register for the change detector, the FIFO and the TX FSM.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            prev_q       <= 32'h0;
            prev_valid_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            state_q      <= ST_IDLE;
            word_q       <= 32'h0;
            char_idx_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            baud_q       <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            word_q       <= word_d;
            char_idx_q   <= char_idx_d;
            bit_idx_q    <= bit_idx_d;
            baud_q       <= baud_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_test_out_uart.sv
module tb_test_out_uart;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef TEST_OUT_UART_PARITY_EN
    localparam int BITS_PER_CHAR = 11;
`else
    localparam int BITS_PER_CHAR = 10;
`endif
    localparam int WORD_CYC = 10 * BITS_PER_CHAR * CPB;
    localparam int STOP_MID = (BITS_PER_CHAR - 1) * CPB + HALF;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] test_out;
    logic        tx, busy, overflow;

    int tests = 0;
    int fails = 0;

    test_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk(clk), .rest(rest), .test_out(test_out),
        .tx(tx), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    // Reference formatting: 8 uppercase hex digits, MS nibble first.
    function automatic string hexword(input logic [31:0] v);
        string digits = "0123456789ABCDEF";
        string s = "";
        for (int i = 7; i >= 0; i--) begin
            int n = int'((v >> (4 * i)) & 32'hF);
            s = {s, digits.substr(n, n)};
        end
        return s;
    endfunction

    // UART receiver model, sampling mid-bit on the falling clock edge.
    logic [7:0] rx_q[$];
    bit         par_q[$];
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte;

    initial begin
        forever begin
            @(negedge clk);
            if (rest === 1'b1) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == HALF) chk("start_bit", tx, 0);
                for (int i = 0; i < 8; i++) begin
                    if (mon_cnt == CPB * (i + 1) + HALF) mon_byte[i] = tx;
                end
`ifdef TEST_OUT_UART_PARITY_EN
                if (mon_cnt == 9 * CPB + HALF) begin
                    chk("parity_bit", tx, ^mon_byte);
                    par_q.push_back(tx);
                end
`endif
                if (mon_cnt == STOP_MID) begin
                    chk("stop_bit", tx, 1);
                    rx_q.push_back(mon_byte);
                    mon_active = 1'b0;
                end
            end
        end
    end

    logic [7:0] wb[10];
    string      wstr;

    // Wait, bounded, for 10 received bytes and split them into text and terminator.
    task automatic get_word(input string name);
        int n = 0;
        while (rx_q.size() < 10 && n < 2 * WORD_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        if (rx_q.size() < 10) begin
            chk({name, "_timeout"}, rx_q.size(), 10);
            wstr = "";
            for (int i = 0; i < 10; i++) wb[i] = 8'h00;
        end else begin
            wstr = "";
            for (int i = 0; i < 10; i++) begin
                wb[i] = rx_q.pop_front();
                if (i < 8) wstr = $sformatf("%s%c", wstr, wb[i]);
            end
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] v);
        get_word(name);
        chk_s(name, wstr, hexword(v));
        chk({name, "_crlf"}, {wb[8], wb[9]}, 16'h0D0A);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        repeat (3) @(negedge clk);
        while (busy !== 1'b0 && n < 6 * WORD_CYC) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) chk({name, "_idle_timeout"}, busy, 0);
        // Allow the receiver to finish the last stop bit.
        repeat (CPB) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] val;
        string       txt;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] ovf_vals[6];
    logic [31:0] model_prev;
    logic [31:0] exp_q[$];
    logic [31:0] pool[3];
    int          n;

    initial begin
        vecs[0] = '{32'h0123ABCD, "0123ABCD"};
        vecs[1] = '{32'hFFFFFFFF, "FFFFFFFF"};
        vecs[2] = '{32'h9A8B7C6D, "9A8B7C6D"};
        vecs[3] = '{32'hF0F0F0F0, "F0F0F0F0"};

        // Reset hold.
        rest     = 1'b1;
        test_out = 32'h12345678;
        repeat (5) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        rest = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_start_latency", n, 2);
        n = 0;
        while (busy !== 1'b0 && n < WORD_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        chk("word_length", n, WORD_CYC);
        check_word("reset_word", 32'h12345678);
        wait_idle("reset_word");

        // Hex case.
        test_out = 32'h0;
        @(negedge clk);
        test_out = 32'hDEADBEEF;
        check_word("zero_word", 32'h0);
        check_word("deadbeef_word", 32'hDEADBEEF);
        chk("char_D", wb[0], 8'h44);
        chk("char_B", wb[4], 8'h42);
        wait_idle("deadbeef");

        // A held constant value is logged exactly once.
        test_out = 32'h000000A5;
        repeat (5000) @(negedge clk);
        chk("const_bytes", rx_q.size(), 10);
        check_word("const_word", 32'h000000A5);
        chk("const_tx_idle", tx, 1);
        chk("const_busy", busy, 0);

        // Table of single values.
        for (int i = 0; i < 4; i++) begin
            test_out = vecs[i].val;
            get_word("table_word");
            chk_s("table_word", wstr, vecs[i].txt);
            wait_idle("table");
        end

        // Overflow: six changes on six consecutive cycles.
        for (int i = 0; i < 6; i++) ovf_vals[i] = 32'h11111111 * (i + 1);
        for (int i = 0; i < 6; i++) begin
            test_out = ovf_vals[i];
            @(negedge clk);
        end
        chk("overflow_set", overflow, 1);
        for (int i = 0; i < 5; i++) check_word("overflow_word", ovf_vals[i]);
        wait_idle("overflow");
        chk("overflow_sticky", overflow, 1);
        chk("overflow_dropped", rx_q.size(), 0);

        // Reset during the data bits of char 3.
        test_out = 32'hCAFE1234;
        n = 0;
        while (!(rx_q.size() == 3 && mon_active && mon_cnt >= 2 * CPB + HALF) && n < WORD_CYC) begin
            @(negedge clk);
            n++;
        end
        chk("midframe_reached", rx_q.size(), 3);
        chk_s("midframe_partial",
              $sformatf("%c%c%c", rx_q[0], rx_q[1], rx_q[2]), "CAF");
        rest = 1'b1;
        #1;
        chk("midframe_tx", tx, 1);
        chk("midframe_busy", busy, 0);
        chk("midframe_overflow", overflow, 0);
        rx_q.delete();
        repeat (4) @(negedge clk);
        rest = 1'b0;
        check_word("midframe_resend", 32'hCAFE1234);
        wait_idle("midframe");
        chk("midframe_single", rx_q.size(), 0);

`ifdef TEST_OUT_UART_PARITY_EN
        // Parity bits for '0', '3' and CR.
        par_q.delete();
        test_out = 32'h00000003;
        check_word("parity_word", 32'h00000003);
        chk("parity_0", par_q[0], 0);
        chk("parity_3", par_q[7], 0);
        chk("parity_cr", par_q[8], 1);
        wait_idle("parity");
`endif

        // Randomized bursts, checked against a change-detect queue model.
        model_prev = test_out;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 3; k++) pool[k] = $urandom;
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                test_out = pool[$urandom_range(0, 2)];
                if (test_out != model_prev) exp_q.push_back(test_out);
                model_prev = test_out;
                @(negedge clk);
            end
            while (exp_q.size() > 0) check_word("random_word", exp_q.pop_front());
            wait_idle("random");
            chk("random_no_extra", rx_q.size(), 0);
        end
        chk("final_overflow", overflow, 0);
        chk("final_tx", tx, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
